// File: rtl/modulo_controle_ataque_if.sv
// Signal bundle between the attack sequencer and the rest of the naval-battle
// game (button debouncers, position/attack register matrices, display drivers).
//
// Handshake: there is no valid/ready pair. start, btn_count and btn_confirm
// are single-cycle pulses accepted only when the sequencer is in a state that
// uses them (otherwise silently dropped). po_bit and at_bit are combinational
// reads of the matrices at (cur_col, cur_row), valid in the same cycle.
// at_we is a one-cycle write strobe qualifying at_hit.
//
// Modports:
//   master - game side: drives pulses and matrix read bits, observes outputs
//   slave  - the sequencer (modulo_controle_ataque)
interface modulo_controle_ataque_if;
  logic       start;
  logic       btn_count;
  logic       btn_confirm;
  logic       po_bit;
  logic       at_bit;
  logic [2:0] cur_col;
  logic [2:0] cur_row;
  logic       at_we;
  logic       at_hit;
  logic [3:0] status;
  logic [4:0] shots;
  logic [3:0] hits;
  logic [1:0] rgb_output;
  logic       game_over;

  modport master (
    output start, btn_count, btn_confirm, po_bit, at_bit,
    input  cur_col, cur_row, at_we, at_hit, status, shots, hits,
           rgb_output, game_over
  );

  modport slave (
    input  start, btn_count, btn_confirm, po_bit, at_bit,
    output cur_col, cur_row, at_we, at_hit, status, shots, hits,
           rgb_output, game_over
  );
endinterface

// File: rtl/modulo_controle_ataque.sv
// Attack-phase sequencer for the naval-battle game on the 5x7 LED matrix.
// Owns the attack cursor, fires shots into the attack register matrix, keeps
// shot/hit counters, drives the 7-segment status code and RGB result LED and
// declares win or lose.
//
// Ports:
//   clk       - system clock (divided domain)
//   clr       - synchronous active-high reset, overrides everything
//   bus       - modulo_controle_ataque_if.slave (pulses, matrix bits, outputs)
//   dbg_state - current FSM state encoding, for observation only
//
// All outputs are registered: the combinational process computes the next
// value of every output register, the sequential process only stores it.
module modulo_controle_ataque #(
  parameter int NUM_COLS      = 5,
  parameter int NUM_ROWS      = 7,
  parameter int MAX_SHOTS     = 20,
  parameter int SHIP_CELLS    = 9,
  parameter int RESULT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    clr,
  modulo_controle_ataque_if.slave bus,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_CHECK  = 3'd2,
    S_WRITE  = 3'd3,
    S_RESULT = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_t;

  localparam logic [3:0] ST_IDLE   = 4'h0;
  localparam logic [3:0] ST_AIM    = 4'h1;
  localparam logic [3:0] ST_HIT    = 4'h2;
  localparam logic [3:0] ST_MISS   = 4'h3;
  localparam logic [3:0] ST_REPEAT = 4'h4;
  localparam logic [3:0] ST_WIN    = 4'h5;
  localparam logic [3:0] ST_LOSE   = 4'h6;

  localparam logic [1:0] RGB_OFF   = 2'b00;
  localparam logic [1:0] RGB_GREEN = 2'b01;
  localparam logic [1:0] RGB_RED   = 2'b10;

  localparam logic [2:0]  LAST_COL  = 3'(NUM_COLS - 1);
  localparam logic [2:0]  LAST_ROW  = 3'(NUM_ROWS - 1);
  localparam logic [4:0]  SHOT_MAX  = 5'(MAX_SHOTS);
  localparam logic [3:0]  HIT_MAX   = 4'(SHIP_CELLS);
  localparam logic [15:0] HOLD_LOAD = 16'(RESULT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic        we_q, we_d;
  logic        hit_q, hit_d;
  logic [3:0]  status_q, status_d;
  logic [4:0]  shots_q, shots_d;
  logic [3:0]  hits_q, hits_d;
  logic [1:0]  rgb_q, rgb_d;
  logic        over_q, over_d;
  logic [15:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      col_q    <= 3'd0;
      row_q    <= 3'd0;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      status_q <= ST_IDLE;
      shots_q  <= 5'd0;
      hits_q   <= 4'd0;
      rgb_q    <= RGB_OFF;
      over_q   <= 1'b0;
      hold_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      we_q     <= we_d;
      hit_q    <= hit_d;
      status_q <= status_d;
      shots_q  <= shots_d;
      hits_q   <= hits_d;
      rgb_q    <= rgb_d;
      over_q   <= over_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    we_d     = 1'b0;
    hit_d    = 1'b0;
    status_d = status_q;
    shots_d  = shots_q;
    hits_d   = hits_q;
    rgb_d    = rgb_q;
    over_d   = over_q;
    hold_d   = hold_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_AIM;
          shots_d  = 5'd0;
          hits_d   = 4'd0;
          status_d = ST_AIM;
        end
      end

      S_AIM: begin
        // Confirm has priority: a simultaneous count press is dropped so the
        // shot lands on the cell the player was looking at.
        if (bus.btn_confirm) begin
          state_d = S_CHECK;
        end else if (bus.btn_count) begin
          status_d = ST_AIM;
          if (row_q == LAST_ROW) begin
            row_d = 3'd0;
            col_d = (col_q == LAST_COL) ? 3'd0 : col_q + 3'd1;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end

      S_CHECK: begin
        if (bus.at_bit) begin
          state_d  = S_AIM;
          status_d = ST_REPEAT;
        end else begin
          // Strobe is registered so it is high exactly during WRITE.
          state_d = S_WRITE;
          we_d    = 1'b1;
          hit_d   = bus.po_bit;
        end
      end

      S_WRITE: begin
        // hit_q holds the po_bit captured alongside the strobe.
        state_d  = S_RESULT;
        hold_d   = HOLD_LOAD;
        shots_d  = (shots_q < SHOT_MAX) ? shots_q + 5'd1 : shots_q;
        if (hit_q && (hits_q < HIT_MAX)) begin
          hits_d = hits_q + 4'd1;
        end
        status_d = hit_q ? ST_HIT : ST_MISS;
        rgb_d    = hit_q ? RGB_GREEN : RGB_RED;
      end

      S_RESULT: begin
        // Loaded with RESULT_CYCLES-1 so the state lasts RESULT_CYCLES cycles.
        if (hold_q == 16'd0) begin
          if (hits_q == HIT_MAX) begin
            state_d  = S_WIN;
            status_d = ST_WIN;
            rgb_d    = RGB_GREEN;
            over_d   = 1'b1;
          end else if (shots_q == SHOT_MAX) begin
            state_d  = S_LOSE;
            status_d = ST_LOSE;
            rgb_d    = RGB_RED;
            over_d   = 1'b1;
          end else begin
            state_d  = S_AIM;
            status_d = ST_AIM;
            rgb_d    = RGB_OFF;
          end
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end

      S_WIN, S_LOSE: begin
        if (bus.start) begin
          state_d  = S_IDLE;
          shots_d  = 5'd0;
          hits_d   = 4'd0;
          col_d    = 3'd0;
          row_d    = 3'd0;
          rgb_d    = RGB_OFF;
          over_d   = 1'b0;
          status_d = ST_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cur_col    = col_q;
  assign bus.cur_row    = row_q;
  assign bus.at_we      = we_q;
  assign bus.at_hit     = hit_q;
  assign bus.status     = status_q;
  assign bus.shots      = shots_q;
  assign bus.hits       = hits_q;
  assign bus.rgb_output = rgb_q;
  assign bus.game_over  = over_q;
  assign dbg_state      = state_q;

endmodule
